// File: rtl/reset_seq_pkg.sv
// Shared state encoding and default prescaler reload for reset_sequencer.
// SIMULATE_DESIGN selects a short reload so simulations reach the sequence quickly.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_INIT     = 3'd1,
    S_WAIT_PLT = 3'd2,
    S_REL      = 3'd3,
    S_RUN      = 3'd4,
    S_ASSERT   = 3'd5
  } seq_state_t;

`ifdef SIMULATE_DESIGN
  localparam logic [15:0] DIV_VAL_DEFAULT = 16'h0001;
`else
  localparam logic [15:0] DIV_VAL_DEFAULT = 16'h01F7;
`endif

endpackage

// File: rtl/reset_seq_prescaler.sv
// Tick prescaler and 32.768 kHz clock for reset_sequencer; held idle (CLK32KHz=1) while disabled.
module reset_seq_prescaler
  import reset_seq_pkg::*;
#(
  parameter logic [15:0] DIV_VAL = DIV_VAL_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_tick,
  output logic o_clk32k
);

  logic [15:0] r_div_cnt;
  logic        r_tick;
  logic        r_clk32k;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div_cnt <= DIV_VAL;
      r_tick    <= 1'b0;
      r_clk32k  <= 1'b1;
    end else if (!i_en) begin
      r_div_cnt <= DIV_VAL;
      r_tick    <= 1'b0;
      r_clk32k  <= 1'b1;
    end else if (r_div_cnt == '0) begin
      // Tick and the clock toggle are registered together, so both stay glitch-free.
      r_div_cnt <= DIV_VAL;
      r_tick    <= 1'b1;
      r_clk32k  <= ~r_clk32k;
    end else begin
      r_div_cnt <= r_div_cnt - 16'd1;
      r_tick    <= 1'b0;
    end
  end

  assign o_tick   = r_tick;
  assign o_clk32k = r_clk32k;

endmodule

// File: rtl/reset_sequencer.sv
// Power-on/platform reset sequencer: InitResetn after a programmable delay, then ordered channel releases.
// RESET_SEQ_REVERSE_EN: on PLTRST_N low, released channels are re-asserted highest first, one per CH_DLY Ticks.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter logic [15:0] DIV_VAL    = DIV_VAL_DEFAULT,
  parameter int unsigned INIT_TICKS = 31,
  parameter int unsigned CH_DLY     = 8,
  parameter int unsigned CNT_W      = 8
) (
  input  logic              MCLKi,
  input  logic              HARD_nRESETi,
  input  logic              RSMRST_N,
  input  logic              PLTRST_N,
  output logic              Tick,
  output logic              CLK32KHz,
  output logic              InitResetn,
  output logic [NUM_CH-1:0] ChResetN,
  output logic              SeqDone,
  output logic [2:0]        SeqState
);

  localparam int unsigned       IDX_W     = $clog2(NUM_CH) + 1;
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_TICKS - 1);
  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(CH_DLY - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_CH - 1);

  logic [1:0]        r_rsm_sync, r_plt_sync;
  logic              w_rsm_s, w_plt_s, w_tick, w_abort;
  seq_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_tick_cnt, w_tick_cnt_nxt;
  logic [IDX_W-1:0]  r_ch_idx, w_ch_idx_nxt;
  logic              r_init_n, w_init_n_nxt;
  logic [NUM_CH-1:0] r_ch_n, w_ch_n_nxt;
  logic              r_done, w_done_nxt;

  function automatic logic [NUM_CH-1:0] idx_mask(input logic [IDX_W-1:0] idx);
    logic [NUM_CH-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NUM_CH; i++)
      if (i == 32'(idx)) m[i] = 1'b1;
    return m;
  endfunction

  always_ff @(posedge MCLKi or negedge HARD_nRESETi) begin
    if (!HARD_nRESETi) begin
      r_rsm_sync <= '0;
      r_plt_sync <= '0;
    end else begin
      r_rsm_sync <= {r_rsm_sync[0], RSMRST_N};
      r_plt_sync <= {r_plt_sync[0], PLTRST_N};
    end
  end

  assign w_rsm_s = r_rsm_sync[1];
  assign w_plt_s = r_plt_sync[1];

  reset_seq_prescaler #(.DIV_VAL(DIV_VAL)) u_prescaler (
    .i_clk    (MCLKi),
    .i_rst_n  (HARD_nRESETi),
    .i_en     (w_rsm_s),
    .o_tick   (w_tick),
    .o_clk32k (CLK32KHz)
  );

  always_ff @(posedge MCLKi or negedge HARD_nRESETi) begin
    if (!HARD_nRESETi) begin
      r_state    <= S_OFF;
      r_tick_cnt <= '0;
      r_ch_idx   <= '0;
      r_init_n   <= 1'b0;
      r_ch_n     <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tick_cnt <= w_tick_cnt_nxt;
      r_ch_idx   <= w_ch_idx_nxt;
      r_init_n   <= w_init_n_nxt;
      r_ch_n     <= w_ch_n_nxt;
      r_done     <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_tick_cnt_nxt = r_tick_cnt;
    w_ch_idx_nxt   = r_ch_idx;
    w_init_n_nxt   = r_init_n;
    w_ch_n_nxt     = r_ch_n;
    w_done_nxt     = r_done;
    w_abort        = 1'b0;

    if (!w_rsm_s) begin
      w_state_nxt    = S_OFF;
      w_tick_cnt_nxt = '0;
      w_ch_idx_nxt   = '0;
      w_init_n_nxt   = 1'b0;
      w_ch_n_nxt     = '0;
      w_done_nxt     = 1'b0;
    end else begin
      case (r_state)
        S_OFF: begin
          w_state_nxt    = S_INIT;
          w_tick_cnt_nxt = '0;
        end
        S_INIT: begin
          if (w_tick) begin
            if (r_tick_cnt == INIT_LAST) begin
              w_init_n_nxt   = 1'b1;
              w_tick_cnt_nxt = '0;
              w_state_nxt    = S_WAIT_PLT;
            end else if (r_tick_cnt != '1) begin
              w_tick_cnt_nxt = r_tick_cnt + CNT_W'(1);
            end
          end
        end
        S_WAIT_PLT: begin
          if (w_plt_s) begin
            w_state_nxt    = S_REL;
            w_ch_idx_nxt   = '0;
            w_tick_cnt_nxt = '0;
          end
        end
        S_REL: begin
          if (!w_plt_s) begin
            w_abort = 1'b1;
          end else if (w_tick) begin
            if (r_tick_cnt == DLY_LAST) begin
              w_ch_n_nxt     = r_ch_n | idx_mask(r_ch_idx);
              w_ch_idx_nxt   = r_ch_idx + IDX_W'(1);
              w_tick_cnt_nxt = '0;
              if (r_ch_idx == IDX_LAST) begin
                w_state_nxt = S_RUN;
                w_done_nxt  = 1'b1;
              end
            end else if (r_tick_cnt != '1) begin
              w_tick_cnt_nxt = r_tick_cnt + CNT_W'(1);
            end
          end
        end
        S_RUN: begin
          if (!w_plt_s) w_abort = 1'b1;
        end
`ifdef RESET_SEQ_REVERSE_EN
        S_ASSERT: begin
          if (r_ch_idx == '0) begin
            w_state_nxt = S_WAIT_PLT;
          end else if (w_tick) begin
            if (r_tick_cnt == DLY_LAST) begin
              w_ch_n_nxt     = r_ch_n & ~idx_mask(r_ch_idx - IDX_W'(1));
              w_ch_idx_nxt   = r_ch_idx - IDX_W'(1);
              w_tick_cnt_nxt = '0;
            end else if (r_tick_cnt != '1) begin
              w_tick_cnt_nxt = r_tick_cnt + CNT_W'(1);
            end
          end
        end
`endif
        default: w_state_nxt = S_OFF;
      endcase

      // chIdx counts released channels, so the highest released one is chIdx-1.
      if (w_abort) begin
        w_done_nxt     = 1'b0;
        w_tick_cnt_nxt = '0;
`ifdef RESET_SEQ_REVERSE_EN
        w_state_nxt = S_ASSERT;
        if (r_ch_idx != '0) begin
          w_ch_n_nxt   = r_ch_n & ~idx_mask(r_ch_idx - IDX_W'(1));
          w_ch_idx_nxt = r_ch_idx - IDX_W'(1);
        end
`else
        w_state_nxt  = S_WAIT_PLT;
        w_ch_n_nxt   = '0;
        w_ch_idx_nxt = '0;
`endif
      end
    end
  end

  assign Tick       = w_tick;
  assign InitResetn = r_init_n;
  assign ChResetN   = r_ch_n;
  assign SeqDone    = r_done;
  assign SeqState   = r_state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: expected output steps (with Tick-count windows) are queued by
// the stimulus and checked by an independent monitor on every change of {InitResetn, SeqDone, ChResetN}.
`timescale 1ns/1ps
module tb_reset_sequencer;

  localparam int unsigned NCH    = 4;
  localparam int unsigned INIT_T = 4;
  localparam int unsigned DLY    = 2;
  localparam int unsigned BIG    = 100000;

  logic           MCLKi = 1'b0;
  logic           HARD_nRESETi, RSMRST_N, PLTRST_N;
  logic           Tick, CLK32KHz, InitResetn, SeqDone;
  logic [NCH-1:0] ChResetN;
  logic [2:0]     SeqState;

  reset_sequencer #(
    .NUM_CH     (NCH),
    .DIV_VAL    (16'h0001),
    .INIT_TICKS (INIT_T),
    .CH_DLY     (DLY),
    .CNT_W      (8)
  ) dut (
    .MCLKi        (MCLKi),
    .HARD_nRESETi (HARD_nRESETi),
    .RSMRST_N     (RSMRST_N),
    .PLTRST_N     (PLTRST_N),
    .Tick         (Tick),
    .CLK32KHz     (CLK32KHz),
    .InitResetn   (InitResetn),
    .ChResetN     (ChResetN),
    .SeqDone      (SeqDone),
    .SeqState     (SeqState)
  );

  always #15 MCLKi = ~MCLKi;

  typedef struct {
    logic [5:0]  vec;
    int unsigned lo;
    int unsigned hi;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;

  function automatic logic [NCH-1:0] released(input int unsigned n);
    logic [NCH-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < n && i < NCH; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic push(input logic [5:0] v, input int unsigned lo, input int unsigned hi);
    exp_t e;
    e.vec = v; e.lo = lo; e.hi = hi;
    exp_q.push_back(e);
  endtask

  // Ordered release of channels 0..n_end-1; SeqDone rises together with the last channel.
  task automatic push_release(input int unsigned n_end, input int unsigned lo0, input int unsigned hi0);
    for (int unsigned n = 1; n <= n_end; n++)
      push({1'b1, (n == NCH), released(n)}, (n == 1) ? lo0 : DLY, (n == 1) ? hi0 : DLY);
  endtask

  task automatic push_assert_from(input int unsigned n);
`ifdef RESET_SEQ_REVERSE_EN
    for (int j = int'(n) - 1; j >= 0; j--)
      push({2'b10, released(unsigned'(j))}, (j == int'(n) - 1) ? 0 : DLY,
           (j == int'(n) - 1) ? BIG : DLY);
`else
    if (n > 0) push({2'b10, {NCH{1'b0}}}, 0, BIG);
`endif
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) @(negedge MCLKi);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic wait_empty(input string name, input int unsigned budget);
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge MCLKi);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout actual=%0d_pending required=0_pending", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_ch(input string name, input logic [NCH-1:0] m, input int unsigned budget);
    int unsigned n;
    n = 0;
    while (ChResetN !== m && n < budget) begin
      @(negedge MCLKi);
      n++;
    end
    checks++;
    if (ChResetN !== m) begin
      failures++;
      $display("FAIL %s_timeout actual=%b required=%b", name, ChResetN, m);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_tick"},     32'(Tick),       32'd0);
    chk({tag, "_clk32k"},   32'(CLK32KHz),   32'd1);
    chk({tag, "_init"},     32'(InitResetn), 32'd0);
    chk({tag, "_ch"},       32'(ChResetN),   32'd0);
    chk({tag, "_done"},     32'(SeqDone),    32'd0);
    chk({tag, "_state"},    32'(SeqState),   32'd0);
  endtask

  // Monitor: Ticks are counted from the cycle of one output change up to the cycle before the next.
  initial begin
    logic [5:0]  prev, cur;
    int unsigned ticks;
    exp_t        e;
    wait (mon_en);
    prev  = '0;
    ticks = 0;
    forever begin
      @(negedge MCLKi);
      cur = {InitResetn, SeqDone, ChResetN};
      if (cur !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change actual=%b required=%b", cur, prev);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e.vec || ticks < e.lo || ticks > e.hi) begin
            failures++;
            $display("FAIL seq_step actual=%b@%0dticks required=%b@%0d..%0dticks",
                     cur, ticks, e.vec, e.lo, e.hi);
          end
        end
        prev  = cur;
        ticks = 0;
      end
      if (Tick === 1'b1) ticks++;
    end
  end

  initial begin
    int unsigned kind, k;
    HARD_nRESETi = 1'b0;
    RSMRST_N     = 1'b1;
    PLTRST_N     = 1'b1;
    cyc(3);
    reset_checks("por");

    push({2'b10, {NCH{1'b0}}}, INIT_T, INIT_T);
    push_release(NCH, DLY, DLY);
    mon_en       = 1'b1;
    HARD_nRESETi = 1'b1;
    wait_empty("powerup", 400);
    chk("run_state", 32'(SeqState), 32'd4);

    for (int it = 0; it < 10; it++) begin
      kind = $urandom_range(0, 3);
      k    = $urandom_range(1, NCH - 1);
      cyc($urandom_range(0, 15));
      case (kind)
        0: begin
          push_assert_from(NCH);
          PLTRST_N = 1'b0;
          wait_empty("plt_low_run", 200);
          chk("init_held", 32'(InitResetn), 32'd1);
          cyc($urandom_range(1, 10));
          push_release(NCH, DLY, BIG);
          PLTRST_N = 1'b1;
          wait_empty("plt_replay", 200);
        end
        1: begin
          push_assert_from(NCH);
          PLTRST_N = 1'b0;
          wait_empty("abort_pre", 200);
          cyc($urandom_range(1, 10));
          push_release(k, DLY, BIG);
          PLTRST_N = 1'b1;
          wait_ch("abort_reach", released(k), 200);
          push_assert_from(k);
          PLTRST_N = 1'b0;
          wait_empty("abort_mid", 200);
          chk("abort_done", 32'(SeqDone), 32'd0);
          cyc($urandom_range(1, 10));
          push_release(NCH, DLY, BIG);
          PLTRST_N = 1'b1;
          wait_empty("abort_replay", 200);
        end
        2: begin
          push_assert_from(NCH);
          PLTRST_N = 1'b0;
          wait_empty("rsm_pre", 200);
          push_release(k, DLY, BIG);
          PLTRST_N = 1'b1;
          wait_ch("rsm_reach", released(k), 200);
          push(6'b0, 0, BIG);
          RSMRST_N = 1'b0;
          cyc(4);
          reset_checks("rsm_drop");
          wait_empty("rsm_drop", 50);
          cyc($urandom_range(1, 10));
          push({2'b10, {NCH{1'b0}}}, INIT_T, INIT_T);
          push_release(NCH, DLY, DLY);
          RSMRST_N = 1'b1;
          wait_empty("rsm_restart", 400);
        end
        default: begin
          push(6'b0, 0, BIG);
          @(posedge MCLKi);
          #($urandom_range(1, 14));
          HARD_nRESETi = 1'b0;
          cyc(2);
          reset_checks("hard");
          wait_empty("hard_drop", 20);
          push({2'b10, {NCH{1'b0}}}, INIT_T, INIT_T);
          push_release(NCH, DLY, DLY);
          HARD_nRESETi = 1'b1;
          wait_empty("hard_restart", 400);
        end
      endcase
      chk("seq_done_end", 32'(SeqDone), 32'd1);
    end

    cyc(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
